// File: rtl/sqrt_dispatch.sv
// Host-side driver for the asynchronous CORDIC square-root core: takes operands on a
// valid/ready stream, launches the core with a reset pulse and returns the root or a timeout.
module sqrt_dispatch #(
  parameter int DW      = 32,
  parameter int RST_CYC = 2,
  parameter int TO_CYC  = 4096
) (
  input  logic          ck,
  input  logic          arst,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [DW-1:0] op_data,
  output logic [DW-1:0] core_data,
  output logic          core_arst_n,
  input  logic          core_finished,
  input  logic [DW-1:0] core_result,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_data,
  output logic          res_err
);

  localparam int CW = $clog2(TO_CYC) + 1;

  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, HOLD} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt;
  logic          fin_m, fin_s, armed;
  logic          handshake, accept, timeout, launch_done;

  assign handshake   = op_valid && op_ready;
  assign launch_done = (state == LAUNCH) && (cnt == CW'(RST_CYC - 1));
  // A finished flag already high on WAIT entry belongs to a previous job; only a fresh rise counts.
  assign accept      = (state == WAIT) && armed && fin_s;
  assign timeout     = (state == WAIT) && (cnt == CW'(TO_CYC - 1));
  assign res_valid   = (state == HOLD);

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (handshake) state_nx = LAUNCH;
      LAUNCH:  if (launch_done) state_nx = WAIT;
      WAIT:    if (accept || timeout) state_nx = HOLD;
      HOLD:    if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      state    <= IDLE;
      op_ready <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_nx;
      op_ready <= (state_nx == IDLE);
      if ((state != state_nx) && (state_nx == LAUNCH || state_nx == WAIT))
        cnt <= '0;
      else if (cnt != '1)
        cnt <= cnt + CW'(1);
    end
  end

  // The launch pulse trails the state by one cycle so the operand settles on data_i first.
  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      core_arst_n <= 1'b0;
      core_data   <= '0;
    end else begin
      core_arst_n <= (state != LAUNCH);
      if (handshake)
        core_data <= op_data;
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      fin_m <= 1'b0;
      fin_s <= 1'b0;
      armed <= 1'b0;
    end else begin
      fin_m <= core_finished;
      fin_s <= fin_m;
      if (state != WAIT)
        armed <= 1'b0;
      else if (!fin_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge ck or posedge arst) begin
    if (arst) begin
      res_data <= '0;
      res_err  <= 1'b0;
    end else if (accept) begin
      res_data <= core_result;
      res_err  <= 1'b0;
    end else if (timeout) begin
      res_data <= '0;
      res_err  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sqrt_dispatch.sv
// Self-checking bench for sqrt_dispatch: an edge-timestamp model checked every cycle,
// plus directed jobs with hand-computed latencies and results.
module tb_sqrt_dispatch;

  localparam int DW      = 32;
  localparam int RST_CYC = 2;
  localparam int TO_CYC  = 64;

  logic          ck = 1'b0;
  logic          arst;
  logic          op_valid = 1'b0;
  logic          op_ready;
  logic [DW-1:0] op_data = '0;
  logic [DW-1:0] core_data;
  logic          core_arst_n;
  logic          core_finished = 1'b0;
  logic [DW-1:0] core_result = '0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [DW-1:0] res_data;
  logic          res_err;

  int checks = 0;
  int passes = 0;
  int tick   = 0;

  sqrt_dispatch #(.DW(DW), .RST_CYC(RST_CYC), .TO_CYC(TO_CYC)) dut (
    .ck(ck), .arst(arst), .op_valid(op_valid), .op_ready(op_ready), .op_data(op_data),
    .core_data(core_data), .core_arst_n(core_arst_n), .core_finished(core_finished),
    .core_result(core_result), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  always #5 ck = ~ck;
  always @(posedge ck) tick++;

  task automatic check_output(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h at t=%0t", name, act, exp, $time);
  endtask

  // Model: jobs described by the edge index of their handshake; the launch window, WAIT entry
  // and timeout deadline follow from it, and finished is seen two edges late.
  int          e = 0, hs_e = 0;
  bit          alive = 0, busy = 0, holding = 0, armed_m = 0, f1 = 0, f2 = 0;
  logic [DW-1:0] m_data = '0, m_res = '0;
  logic          m_err = 1'b0;

  always @(posedge ck or posedge arst) begin
    if (arst) begin
      alive = 0; busy = 0; holding = 0; armed_m = 0; f1 = 0; f2 = 0;
      m_data = '0; m_res = '0; m_err = 1'b0;
    end else begin
      e++;
      if (holding) begin
        if (res_ready) holding = 0;
      end else if (busy) begin
        if (e > hs_e + RST_CYC) begin
          if (armed_m && f2) begin
            m_res = core_result; m_err = 1'b0; busy = 0; holding = 1;
          end else if (e == hs_e + RST_CYC + TO_CYC) begin
            m_res = '0; m_err = 1'b1; busy = 0; holding = 1;
          end
          if (!f2) armed_m = 1;
        end
      end else if (alive && op_valid) begin
        busy = 1; hs_e = e; m_data = op_data; armed_m = 0;
      end
      f2 = f1;
      f1 = core_finished;
      alive = 1;
    end
  end

  always @(negedge ck) begin
    check_output("op_ready", op_ready, alive && !busy && !holding);
    check_output("core_arst_n", core_arst_n,
                 alive && !(busy && e >= hs_e + 1 && e <= hs_e + RST_CYC));
    check_output("core_data", core_data, m_data);
    check_output("res_valid", res_valid, holding);
    check_output("res_data", res_data, m_res);
    check_output("res_err", res_err, m_err);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge ck);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [DW-1:0] data, output int hs);
    op_data  = data;
    op_valid = 1'b1;
    hs = -1;
    for (int i = 0; i < 100 && hs < 0; i++) begin
      if (op_ready) begin
        step(1);
        hs = tick;
      end else begin
        step(1);
      end
    end
    op_valid = 1'b0;
    if (hs < 0) check_output("op accept bound", op_ready, 1'b1);
  endtask

  task automatic wait_res(input int bound, output int t);
    t = -1;
    for (int i = 0; i < bound && t < 0; i++) begin
      if (res_valid) t = tick;
      else step(1);
    end
    if (t < 0) check_output("res_valid bound", res_valid, 1'b1);
  endtask

  task automatic accept_res();
    res_ready = 1'b1;
    step(1);
    res_ready = 1'b0;
  endtask

  initial begin
    int n, t;
    arst = 1'b1;
    #23;
    check_output("rst op_ready", op_ready, 1'b0);
    check_output("rst core_arst_n", core_arst_n, 1'b0);
    check_output("rst res_valid", res_valid, 1'b0);
    arst = 1'b0;
    #1;
    check_output("rel op_ready pre-edge", op_ready, 1'b0);
    step(1);
    check_output("rel op_ready", op_ready, 1'b1);
    check_output("rel core_arst_n", core_arst_n, 1'b1);

    // Single job: sqrt(0x10) = 4, finished 40 cycles after core reset release.
    apply_stimulus(32'h10, n);
    check_output("job1 core_data", core_data, 32'h10);
    check_output("job1 setup arst_n", core_arst_n, 1'b1);
    step(1);
    check_output("job1 pulse c1", core_arst_n, 1'b0);
    step(1);
    check_output("job1 pulse c2", core_arst_n, 1'b0);
    step(1);
    check_output("job1 release", core_arst_n, 1'b1);
    step(40);
    core_result   = 32'h4;
    core_finished = 1'b1;
    wait_res(20, t);
    check_output("job1 latency", DW'(t - n), 32'd46);
    check_output("job1 res_data", res_data, 32'h4);
    check_output("job1 res_err", res_err, 1'b0);

    // Backpressure with the next operand already offered.
    op_data  = 32'h19;
    op_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_output("bp op_ready", op_ready, 1'b0);
      check_output("bp res_data", res_data, 32'h4);
    end
    accept_res();
    check_output("bp op_ready after accept", op_ready, 1'b1);
    check_output("bp res_valid after accept", res_valid, 1'b0);
    step(1);
    n = tick;
    op_valid = 1'b0;
    check_output("bp next core_data", core_data, 32'h19);
    check_output("bp next op_ready", op_ready, 1'b0);

    // Stale finished: still high from job 1, drops 5 cycles after release, rises at 30.
    step(RST_CYC + 1 + 5);
    core_finished = 1'b0;
    core_result   = '0;
    step(25);
    core_result   = 32'h5;
    core_finished = 1'b1;
    wait_res(20, t);
    check_output("stale latency", DW'(t - n), 32'd36);
    check_output("stale res_data", res_data, 32'h5);
    accept_res();
    core_finished = 1'b0;
    check_output("stale once", res_valid, 1'b0);
    step(5);
    check_output("stale once later", res_valid, 1'b0);

    // Timeout: finished never rises.
    apply_stimulus(32'h1234, n);
    wait_res(100, t);
    check_output("to latency", DW'(t - n), 32'd66);
    check_output("to res_err", res_err, 1'b1);
    check_output("to res_data", res_data, 32'h0);
    accept_res();

    // Reset pulse ten cycles into WAIT drops the job.
    apply_stimulus(32'h51, n);
    step(RST_CYC + 10);
    #3 arst = 1'b1;
    #1;
    check_output("mid rst op_ready", op_ready, 1'b0);
    check_output("mid rst core_arst_n", core_arst_n, 1'b0);
    check_output("mid rst core_data", core_data, 32'h0);
    check_output("mid rst res_err", res_err, 1'b0);
    #3 arst = 1'b0;
    step(1);
    check_output("mid rel op_ready", op_ready, 1'b1);
    core_result   = 32'h7;
    core_finished = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1);
      check_output("mid no result", res_valid, 1'b0);
    end
    check_output("mid idle op_ready", op_ready, 1'b1);
    core_finished = 1'b0;
    step(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sqrt_dispatch.md
# sqrt_dispatch

Host-side driver for the asynchronous CORDIC square-root core, sitting on the other end of the core's `data_i` / `arst` / `finished` / `data_o` interface. It accepts operands on a valid/ready stream and holds each one stable on the core's data input. It launches the computation by pulsing the core's reset, then synchronises the core's `finished` flag into `ck`. It captures the core result and returns it on a valid/ready stream, with a timeout error flag.

## Interface
- `DW`, default 32: operand/result width; equals core EW+FW+1.
- `RST_CYC`, default 2: cycles the core reset is held asserted per launch, ≥1.
- `TO_CYC`, default 4096: timeout in `ck` cycles from core reset release to synchronised `finished`, ≥4.
- `ck`  in  1  system clock, single clock domain.
- `arst`  in  1  asynchronous, active-high reset of this block.
- `op_valid`  in  1  operand valid.
- `op_ready`  out  1  operand accepted when `op_valid && op_ready` on a `ck` rising edge.
- `op_data`  in  DW  operand.
- `core_data`  out  DW  drives core `data_i`.
- `core_arst_n`  out  1  drives core `arst`; active-low launch pulse.
- `core_finished`  in  1  core `finished`; asynchronous to `ck`.
- `core_result`  in  DW  core `data_o`; stable while `finished` is high.
- `res_valid`  out  1  result valid.
- `res_ready`  in  1  result accepted when `res_valid && res_ready`.
- `res_data`  out  DW  captured root; 0 on timeout.
- `res_err`  out  1  1 = timeout, qualified by `res_valid`.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, HOLD.
- IDLE: `op_ready`=1. On handshake: latch `op_data` into `core_data`, clear the cycle counter, go to LAUNCH.
- LAUNCH: `core_arst_n`=0 for exactly RST_CYC cycles, then go to WAIT and clear the counter.
- WAIT: `core_arst_n`=1 and the counter increments each cycle.
  - `finished` passes through a 2-FF synchroniser (`fin_s`).
  - A result is accepted only on a 0→1 edge of `fin_s` observed in WAIT. A `fin_s` that is already high on entry is ignored until it has been seen low.
  - On an accepted edge: register `core_result` into `res_data`, `res_err`=0, go to HOLD.
  - If the counter reaches TO_CYC-1 with no accepted edge: `res_data`=0, `res_err`=1, go to HOLD.
- HOLD: `res_valid`=1; `res_data` and `res_err` stay frozen. On `res_ready`, go to IDLE.
- `core_data` holds the last operand in every state until the next accepted operand.
- `op_ready` is low in LAUNCH, WAIT and HOLD. At most one job is in flight; there is no queueing.
- Counter width is ceil(log2(TO_CYC))+1 and it saturates; it never wraps.
- `arst` asserted in any state:
  - immediately forces IDLE, `op_ready`=0, `core_arst_n`=0, `res_valid`=0, `res_data`=0, `res_err`=0, `core_data`=0, and clears the synchroniser and counter.
  - After `arst` deasserts, `core_arst_n`=1 and `op_ready`=1 from the first `ck` edge.
  - An in-flight job is dropped and no result is produced.

## Timing
- Reset values: `op_ready`=0, `core_arst_n`=0, `core_data`=0, `res_valid`=0, `res_data`=0, `res_err`=0.
- Operand handshake at edge N: `core_data` valid after edge N; `core_arst_n` low during cycles N+1 … N+RST_CYC; high from edge N+RST_CYC+1.
- `finished` rising at a time inside cycle M: `fin_s` goes high after edge M+2; `res_valid` goes high after edge M+3.
- Timeout: `res_valid` goes high TO_CYC cycles after WAIT entry.
- Result accepted at edge K: `op_ready`=1 after edge K; next operand accepted at the earliest at edge K+1.
- `res_valid` never deasserts without `res_ready`. `op_valid` while busy is held off by `op_ready`=0; the operand is not lost.

## Test plan
- Reset: assert `arst` mid-cycle → all outputs at reset values asynchronously; `op_ready`=1 one edge after release.
- Single job: `op_data`=0x0000_0010, model core raises `finished` 40 cycles after release with result 0x0000_0004 → `core_arst_n` low exactly RST_CYC cycles; `res_valid` 3 cycles after `finished`; `res_data`=0x4, `res_err`=0.
- Backpressure: `res_ready`=0 for 20 cycles, `op_valid` held high with 0x19 → `res_data` stable, `op_ready`=0 throughout; after `res_ready`, 0x19 is accepted the next cycle.
- Stale finished: model keeps `finished` high through launch and drops it 5 cycles after release, then raises it at 30 with 0x5 → no early capture; result 0x5 reported once.
- Timeout: TO_CYC=64, `finished` never rises → `res_valid` exactly 64 cycles after WAIT entry; `res_err`=1, `res_data`=0.
- Reset mid-WAIT: `arst` pulse 10 cycles into WAIT, then `finished` rises → no `res_valid`; block returns to IDLE with `op_ready`=1.
